vga_adapter: RTL and testbench
==============================

# vga_adapter

Maps a VGA raster pixel coordinate onto the cell of a coarse tile/character memory. Each memory cell covers a WIDTH_SCALE × HEIGHT_SCALE block of screen pixels. The block sits between the VGA timing generator, which supplies the current pixel position, and the frame memory read port, which consumes the cell coordinates and linear address. Outputs are registered, so downstream memory lookup is aligned to a fixed one-cycle latency.

## Interface

One clock; reset is asynchronous and active-high (ports `Clock`, `Reset`).

**Parameters** (positional order as listed)

- VGA_WIDTH, default 640: visible screen width in pixels.
- VGA_HEIGHT, default 480: visible screen height in pixels.
- MEM_WIDTH, default 32: memory columns.
- MEM_HEIGHT, default 24: memory rows.
- WIDTH_SCALE, default 20: pixels per memory column (VGA_WIDTH / MEM_WIDTH).
- HEIGHT_SCALE, default 20: pixels per memory row (VGA_HEIGHT / MEM_HEIGHT).
- MEM_POS_W, default 5: width of each memory-position output.
- ADDR_W, default 10: width of the linear address output; must hold MEM_WIDTH*MEM_HEIGHT-1.

**Ports**

- Clock, input, 1: rising-edge clock.
- Reset, input, 1: asynchronous, active-high reset.
- widthVgaPos, input, 10: pixel column (x).
- heightVgaPos, input, 10: pixel row (y).
- widthMemPos, output, MEM_POS_W: memory column.
- heightMemPos, output, MEM_POS_W: memory row.
- memAddr, output, ADDR_W: linear cell address.
- inRange, output, 1: high when the input pixel lies inside the visible area.

## Operation

- widthMemPos = floor(widthVgaPos / WIDTH_SCALE).
- heightMemPos = floor(heightVgaPos / HEIGHT_SCALE).
- Division is unsigned integer division by a constant parameter, truncating toward zero.
- memAddr = heightMemPos*MEM_WIDTH + widthMemPos.
  - Computed from the same-cycle quotients, not from the previously registered outputs.
  - Truncated to ADDR_W bits.
- inRange = (widthVgaPos < VGA_WIDTH) && (heightVgaPos < VGA_HEIGHT).
- Quotients are unsigned and zero-extended/truncated to MEM_POS_W bits before address formation.
- Out-of-range handling depends on VGA_ADAPTER_CLAMP_EN (see Configuration).
- The block has no internal state other than the output registers. There is no handshake; every cycle samples new inputs.

## Timing

- All outputs are registered on the rising edge of Clock.
- Latency is 1 cycle: outputs after edge k reflect the inputs present just before edge k.
- Inputs held constant give constant outputs.
- When Reset is asserted, all outputs go to 0 immediately, asynchronously: widthMemPos=0, heightMemPos=0, memAddr=0, inRange=0.
- While Reset is high, outputs stay 0 regardless of inputs.
- On Reset deassertion, the first update occurs at the next rising edge using the inputs present at that edge.
- Reset asserted mid-stream discards the pending computation; no stale value appears after release.
- Boundary cases:
  - x=WIDTH_SCALE-1 maps to column 0; x=WIDTH_SCALE maps to column 1.
  - x=VGA_WIDTH-1 maps to column MEM_WIDTH-1; y=VGA_HEIGHT-1 maps to row MEM_HEIGHT-1.

## Configuration

Macro: **VGA_ADAPTER_CLAMP_EN**

- **Defined:**
  - Out-of-range inputs are clamped to the last memory cell: widthMemPos saturates at MEM_WIDTH-1 and heightMemPos at MEM_HEIGHT-1, each axis independently.
  - memAddr is computed from the clamped values.
  - inRange still reports 0.
- **Not defined:**
  - Raw quotients are used, truncated to MEM_POS_W bits.
  - memAddr is computed from these and truncated to ADDR_W bits.
  - inRange is unaffected.
- In-range behaviour is identical in both builds.

## Test plan

All scenarios use default parameters.

- **Reset:** Reset=1 with inputs (0,0), then with inputs (639,479) → all outputs 0 asynchronously and held. After release and one edge with (0,0) → (0,0), memAddr=0, inRange=1.
- **Interior points:**
  - (100,50) → (5,2), memAddr=69.
  - (200,100) → (10,5), memAddr=170.
  - (400,200) → (20,10), memAddr=340.
  - inRange=1 for all, each appearing exactly one edge after the input is applied.
- **Corner and scale edges:**
  - (639,479) → (31,23), memAddr=767.
  - (19,19) → (0,0).
  - (20,20) → (1,1), memAddr=33.
- **Out of range, VGA_ADAPTER_CLAMP_EN defined:** (700,500) → (31,23), memAddr=767, inRange=0. (640,0) → (31,0), inRange=0.
- **Out of range, macro undefined:** (700,500) → (35 mod 32 = 3, 25), memAddr=(25*32+3) mod 1024 = 803, inRange=0.
- **Mid-stream reset:** change input to (400,200) and pulse Reset between edges → outputs 0 during the pulse. After release, the first edge produces (20,10) from the live inputs.

Source files
------------

// File: rtl/vga_adapter.sv
// Maps a VGA pixel coordinate onto a tile-memory cell with registered, 1-cycle-latency outputs.
// Optional build macro VGA_ADAPTER_CLAMP_EN saturates out-of-range positions at the last cell.
module vga_adapter #(
  parameter int unsigned VGA_WIDTH    = 640,
  parameter int unsigned VGA_HEIGHT   = 480,
  parameter int unsigned MEM_WIDTH    = 32,
  parameter int unsigned MEM_HEIGHT   = 24,
  parameter int unsigned WIDTH_SCALE  = 20,
  parameter int unsigned HEIGHT_SCALE = 20,
  parameter int unsigned MEM_POS_W    = 5,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [9:0]           widthVgaPos,
  input  logic [9:0]           heightVgaPos,
  output logic [MEM_POS_W-1:0] widthMemPos,
  output logic [MEM_POS_W-1:0] heightMemPos,
  output logic [ADDR_W-1:0]    memAddr,
  output logic                 inRange
);

  // The last linear address must fit in the address output.
  if (MEM_WIDTH * MEM_HEIGHT > (64'd1 << ADDR_W)) begin : g_addr_check
    $error("ADDR_W too narrow for MEM_WIDTH*MEM_HEIGHT cells");
  end

  logic [9:0]           widthQuot;
  logic [9:0]           heightQuot;
  logic [MEM_POS_W-1:0] widthNext;
  logic [MEM_POS_W-1:0] heightNext;
  logic [31:0]          addrFull;
  logic                 inRangeNext;

  always_comb begin
    widthQuot  = widthVgaPos / 10'(WIDTH_SCALE);
    heightQuot = heightVgaPos / 10'(HEIGHT_SCALE);
`ifdef VGA_ADAPTER_CLAMP_EN
    widthNext  = (widthQuot > 10'(MEM_WIDTH - 1)) ? MEM_POS_W'(MEM_WIDTH - 1)
                                                  : MEM_POS_W'(widthQuot);
    heightNext = (heightQuot > 10'(MEM_HEIGHT - 1)) ? MEM_POS_W'(MEM_HEIGHT - 1)
                                                    : MEM_POS_W'(heightQuot);
`else
    widthNext  = MEM_POS_W'(widthQuot);
    heightNext = MEM_POS_W'(heightQuot);
`endif
    // Address is formed from this cycle's quotients, not the registered outputs.
    addrFull    = 32'(heightNext) * MEM_WIDTH + 32'(widthNext);
    inRangeNext = (32'(widthVgaPos) < VGA_WIDTH) && (32'(heightVgaPos) < VGA_HEIGHT);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      widthMemPos  <= '0;
      heightMemPos <= '0;
      memAddr      <= '0;
      inRange      <= 1'b0;
    end else begin
      widthMemPos  <= widthNext;
      heightMemPos <= heightNext;
      memAddr      <= ADDR_W'(addrFull);
      inRange      <= inRangeNext;
    end
  end

endmodule

// File: tb/tb_vga_adapter.sv
// Self-checking bench for vga_adapter: directed test-plan points plus randomized coordinates
// compared against an arithmetic reference model (honours VGA_ADAPTER_CLAMP_EN).
module tb_vga_adapter;

  localparam int VgaW = 640;
  localparam int VgaH = 480;
  localparam int MemW = 32;
  localparam int MemH = 24;
  localparam int Scale = 20;

  logic       Clock;
  logic       Reset;
  logic [9:0] widthVgaPos;
  logic [9:0] heightVgaPos;
  logic [4:0] widthMemPos;
  logic [4:0] heightMemPos;
  logic [9:0] memAddr;
  logic       inRange;

  int checks = 0;
  int errors = 0;

  vga_adapter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .widthVgaPos  (widthVgaPos),
    .heightVgaPos (heightVgaPos),
    .widthMemPos  (widthMemPos),
    .heightMemPos (heightMemPos),
    .memAddr      (memAddr),
    .inRange      (inRange)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed {col, row, addr, inRange}
  function automatic logic [20:0] model(input int x, input int y);
    int c, r, a;
    bit ir;
    c  = x / Scale;
    r  = y / Scale;
`ifdef VGA_ADAPTER_CLAMP_EN
    if (c > MemW - 1) c = MemW - 1;
    if (r > MemH - 1) r = MemH - 1;
`else
    c = c % 32;
    r = r % 32;
`endif
    a  = (r * MemW + c) % 1024;
    ir = (x < VgaW) && (y < VgaH);
    return {c[4:0], r[4:0], a[9:0], ir};
  endfunction

  function automatic logic [20:0] observed();
    return {widthMemPos, heightMemPos, memAddr, inRange};
  endfunction

  task automatic drive(input int x, input int y);
    @(negedge Clock);
    widthVgaPos  = 10'(x);
    heightVgaPos = 10'(y);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    Reset = 1'b1;
    widthVgaPos = 10'd0;
    heightVgaPos = 10'd0;
    #3;
    got = observed();
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", got, 21'd0);
    end
    drive(639, 479);
    step();
    step();
    got = observed();
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", got, 21'd0);
    end
    drive(0, 0);
    Reset = 1'b0;
    step();
    got = observed();
    checks++;
    if (got !== {5'd0, 5'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", got, {5'd0, 5'd0, 10'd0, 1'b1});
    end
  endtask

  task automatic test_interior();
    int xs[3] = '{100, 200, 400};
    int ys[3] = '{50, 100, 200};
    logic [20:0] exp_t[3];
    logic [20:0] got;
    logic [20:0] prev;
    exp_t[0] = {5'd5, 5'd2, 10'd69, 1'b1};
    exp_t[1] = {5'd10, 5'd5, 10'd170, 1'b1};
    exp_t[2] = {5'd20, 5'd10, 10'd340, 1'b1};
    prev = {5'd0, 5'd0, 10'd0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(xs[i], ys[i]);
      #1;
      got = observed();
      checks++;
      if (got !== prev) begin
        errors++;
        $display("FAIL interior_latency_%0d got=%h exp=%h", i, got, prev);
      end
      step();
      got = observed();
      checks++;
      if (got !== exp_t[i]) begin
        errors++;
        $display("FAIL interior_%0d (%0d,%0d) got col=%0d row=%0d addr=%0d in=%0b exp col=%0d row=%0d addr=%0d in=%0b",
                 i, xs[i], ys[i], got[20:16], got[15:11], got[10:1], got[0],
                 exp_t[i][20:16], exp_t[i][15:11], exp_t[i][10:1], exp_t[i][0]);
      end
      prev = exp_t[i];
    end
  endtask

  task automatic test_corners();
    int xs[3] = '{639, 19, 20};
    int ys[3] = '{479, 19, 20};
    logic [20:0] exp_t[3];
    logic [20:0] got;
    exp_t[0] = {5'd31, 5'd23, 10'd767, 1'b1};
    exp_t[1] = {5'd0, 5'd0, 10'd0, 1'b1};
    exp_t[2] = {5'd1, 5'd1, 10'd33, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(xs[i], ys[i]);
      step();
      got = observed();
      checks++;
      if (got !== exp_t[i]) begin
        errors++;
        $display("FAIL corner_%0d (%0d,%0d) got=%h exp=%h", i, xs[i], ys[i], got, exp_t[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [20:0] got;
    logic [20:0] exp_v;
    drive(700, 500);
    step();
    got = observed();
`ifdef VGA_ADAPTER_CLAMP_EN
    exp_v = {5'd31, 5'd23, 10'd767, 1'b0};
`else
    exp_v = {5'd3, 5'd25, 10'd803, 1'b0};
`endif
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL oor_700_500 got=%h exp=%h", got, exp_v);
    end
    drive(640, 0);
    step();
    got = observed();
`ifdef VGA_ADAPTER_CLAMP_EN
    exp_v = {5'd31, 5'd0, 10'd31, 1'b0};
`else
    exp_v = {5'd0, 5'd0, 10'd0, 1'b0};
`endif
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL oor_640_0 got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_midstream_reset();
    logic [20:0] got;
    drive(100, 50);
    step();
    drive(400, 200);
    #2;
    Reset = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL midreset_async got=%h exp=%h", got, 21'd0);
    end
    step();
    got = observed();
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL midreset_hold got=%h exp=%h", got, 21'd0);
    end
    @(negedge Clock);
    Reset = 1'b0;
    step();
    got = observed();
    checks++;
    if (got !== {5'd20, 5'd10, 10'd340, 1'b1}) begin
      errors++;
      $display("FAIL midreset_release got=%h exp=%h", got, {5'd20, 5'd10, 10'd340, 1'b1});
    end
  endtask

  // Back-to-back random coordinates, a new one every cycle, covering both in- and out-of-range.
  task automatic test_random();
    logic [20:0] got;
    logic [20:0] exp_v;
    int x, y;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        x = int'($urandom_range(0, VgaW - 1));
        y = int'($urandom_range(0, VgaH - 1));
      end else begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      drive(x, y);
      step();
      got   = observed();
      exp_v = model(x, y);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_%0d (%0d,%0d) got col=%0d row=%0d addr=%0d in=%0b exp col=%0d row=%0d addr=%0d in=%0b",
                 i, x, y, got[20:16], got[15:11], got[10:1], got[0],
                 exp_v[20:16], exp_v[15:11], exp_v[10:1], exp_v[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_interior();
    test_corners();
    test_out_of_range();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
